// File: rtl/base_mcmux_arb.sv
// rtl/base_mcmux_arb.sv - credit-gated round-robin arbiter driving an early-valid slotted mux
// Grant is combinational from registered credit count; o_v leads o_d by one cycle.
module base_mcmux_arb #(
  parameter int ways    = 4,
  parameter int width   = 1,
  parameter int credits = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [0:ways-1]       i_v,
  input  logic [0:ways*width-1] i_d,
  output logic [0:ways-1]       o_r,
  output logic [0:ways-1]       o_v,
  output logic [0:ways*width-1] o_d,
  input  logic                  i_credit,
  output logic                  o_idle,
  output logic                  o_err
);
  localparam int CW = $clog2(credits + 1);
  localparam int PW = $clog2(ways);
  localparam logic [CW-1:0] CREDITS_W = CW'(credits);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [PW:0]   WAYS_W    = (PW+1)'(ways);
  localparam logic [PW-1:0] PTR_RST   = PW'(ways - 1);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic                  err_q, err_d;
  logic [0:ways-1]       v1_q, v1_d;
  logic [width-1:0]      d1_q, d1_d;
  logic [0:ways*width-1] od_q, od_d;

  logic [0:ways-1] gnt;
  logic [PW-1:0]   gnt_idx;
  logic            gnt_any;
  logic [PW:0]     cand;

  // Round-robin search starting one past the last winner, wrapping modulo ways.
  always_comb begin
    gnt     = '0;
    gnt_idx = ptr_q;
    gnt_any = 1'b0;
    cand    = '0;
    for (int i = 1; i <= ways; i++) begin
      cand = {1'b0, ptr_q} + (PW+1)'(i);
      if (cand >= WAYS_W) cand = cand - WAYS_W;
      if (!gnt_any && i_v[cand[PW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[PW-1:0];
      end
    end
    if (!reset || cnt_q == '0) gnt_any = 1'b0;
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  always_comb begin
    v1_d = gnt;
    d1_d = '0;
    for (int k = 0; k < ways; k++) begin
      if (gnt[k]) d1_d = i_d[k*width +: width];
    end
    od_d = '0;
    for (int k = 0; k < ways; k++) begin
      if (v1_q[k]) od_d[k*width +: width] = d1_q;
    end
  end

  // A return at full count saturates and latches the overflow flag.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    ptr_d = ptr_q;
    if (gnt_any) ptr_d = gnt_idx;
    if (gnt_any && !i_credit) begin
      cnt_d = cnt_q - CNT_ONE;
    end else if (!gnt_any && i_credit) begin
      if (cnt_q == CREDITS_W) err_d = 1'b1;
      else cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= CREDITS_W;
      ptr_q <= PTR_RST;
      err_q <= 1'b0;
      v1_q  <= '0;
      d1_q  <= '0;
      od_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      err_q <= err_d;
      v1_q  <= v1_d;
      d1_q  <= d1_d;
      od_q  <= od_d;
    end
  end

  assign o_r    = gnt;
  assign o_v    = v1_q;
  assign o_d    = od_q;
  assign o_err  = err_q;
  assign o_idle = (cnt_q == CREDITS_W) && !gnt_any && (v1_q == '0);

endmodule

// File: tb/tb_base_mcmux_arb.sv
// tb/tb_base_mcmux_arb.sv - scoreboard bench for base_mcmux_arb
// Driver predicts grants from a queue-free round-robin model; monitor checks o_v/o_d.
module tb_base_mcmux_arb;
  localparam int WAYS  = 4;
  localparam int WIDTH = 8;
  localparam int CRED  = 4;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic [0:WAYS-1]       i_v, o_r, o_v;
  logic [0:WAYS*WIDTH-1] i_d, o_d;
  logic                  i_credit, o_idle, o_err;

  base_mcmux_arb #(.ways(WAYS), .width(WIDTH), .credits(CRED)) dut (
    .clk(clk), .reset(reset), .i_v(i_v), .i_d(i_d), .o_r(o_r),
    .o_v(o_v), .o_d(o_d), .i_credit(i_credit), .o_idle(o_idle), .o_err(o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               k;
    logic [WIDTH-1:0] d;
    int               cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  logic [0:WAYS*WIDTH-1] od_exp = '0;

  bit               src_v [WAYS];
  logic [WIDTH-1:0] src_d [WAYS];
  int               m_cnt, m_ptr;
  bit               m_err, m_prev;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [0:WAYS-1] onehot(input int k);
    logic [0:WAYS-1] r;
    r = '0;
    if (k >= 0) r[k] = 1'b1;
    return r;
  endfunction

  function automatic logic [0:WAYS*WIDTH-1] slot(input int k, input logic [WIDTH-1:0] d);
    logic [0:WAYS*WIDTH-1] r;
    r = '0;
    r[k*WIDTH +: WIDTH] = d;
    return r;
  endfunction

  always @(negedge clk) begin
    if (!mon_en) begin
      exp_q.delete();
      od_exp = '0;
    end else begin
      chk("o_d", o_d, od_exp);
      od_exp = '0;
      if (exp_q.size() > 0 && exp_q[0].cyc + 1 == cyc) begin
        mon_e = exp_q.pop_front();
        chk("o_v", o_v, onehot(mon_e.k));
        od_exp = slot(mon_e.k, mon_e.d);
      end else begin
        chk("o_v_quiet", o_v, '0);
      end
    end
  end

  // One cycle: drive held requests, predict the grant, update the model.
  task automatic step(input bit cr);
    int   g;
    exp_t e;
    for (int k = 0; k < WAYS; k++) begin
      i_v[k] = src_v[k];
      i_d[k*WIDTH +: WIDTH] = src_d[k];
    end
    i_credit = cr;
    #1;
    g = -1;
    if (m_cnt > 0) begin
      for (int i = 1; i <= WAYS; i++) begin
        if (g < 0 && src_v[(m_ptr + i) % WAYS]) g = (m_ptr + i) % WAYS;
      end
    end
    chk("o_r", o_r, onehot(g));
    chk("o_idle", o_idle, (m_cnt == CRED && g < 0 && !m_prev));
    chk("o_err", o_err, m_err);
    if (g >= 0) begin
      e.k = g;
      e.d = src_d[g];
      e.cyc = cyc;
      exp_q.push_back(e);
      src_v[g] = 1'b0;
      m_ptr = g;
    end
    if (g >= 0 && !cr) m_cnt--;
    else if (g < 0 && cr) begin
      if (m_cnt == CRED) m_err = 1'b1;
      else m_cnt++;
    end
    m_prev = (g >= 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    mon_en = 1'b0;
    i_credit = 1'b0;
    #1;
    chk("rst_o_v", o_v, '0);
    chk("rst_o_d", o_d, '0);
    chk("rst_o_r", o_r, '0);
    chk("rst_o_idle", o_idle, 1);
    chk("rst_o_err", o_err, 0);
    for (int k = 0; k < WAYS; k++) src_v[k] = 1'b0;
    i_v = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    m_cnt = CRED;
    m_ptr = WAYS - 1;
    m_err = 1'b0;
    m_prev = 1'b0;
    mon_en = 1'b1;
    #1;
    chk("rel_o_idle", o_idle, 1);
  endtask

  initial begin
    i_v = '0;
    i_d = '0;
    i_credit = 1'b0;
    for (int k = 0; k < WAYS; k++) begin
      src_v[k] = 1'b0;
      src_d[k] = '0;
    end
    @(posedge clk);
    #1;
    do_reset();

    // All four requesting with four credits: 0,1,2,3 then credit starvation.
    for (int k = 0; k < WAYS; k++) begin
      src_v[k] = 1'b1;
      src_d[k] = 8'(8'h10 + k);
    end
    repeat (6) step(1'b0);
    repeat (4) step(1'b1);
    step(1'b1);
    step(1'b0);
    step(1'b0);
    do_reset();

    // Transfer and return in the same cycle at count 2 leaves count at 2.
    src_v[2] = 1'b1; src_d[2] = 8'hA2; step(1'b0);
    src_v[1] = 1'b1; src_d[1] = 8'hB1; step(1'b0);
    src_v[3] = 1'b1; src_d[3] = 8'hC3; step(1'b1);
    for (int k = 0; k < WAYS; k++) begin
      src_v[k] = 1'b1;
      src_d[k] = 8'(8'h40 + k);
    end
    repeat (4) step(1'b0);
    do_reset();

    // Drain to one credit, then a single source with delayed returns.
    repeat (3) begin
      src_v[0] = 1'b1; src_d[0] = 8'($urandom); step(1'b0);
    end
    repeat (4) begin
      src_v[2] = 1'b1; src_d[2] = 8'($urandom); step(1'b0);
      step(1'b0);
      step(1'b1);
    end
    do_reset();

    // Reset between o_v and o_d of a grant.
    for (int k = 0; k < WAYS; k++) begin
      src_v[k] = 1'b1;
      src_d[k] = 8'(8'h70 + k);
    end
    step(1'b0);
    do_reset();
    for (int k = 0; k < WAYS; k++) begin
      src_v[k] = 1'b1;
      src_d[k] = 8'(8'h80 + k);
    end
    repeat (3) step(1'b0);
    do_reset();

    // Random traffic with mostly well-behaved credit returns.
    for (int n = 0; n < 10000; n++) begin
      bit cr;
      for (int k = 0; k < WAYS; k++) begin
        if (!src_v[k] && $urandom_range(0, 99) < 55) begin
          src_v[k] = 1'b1;
          src_d[k] = 8'($urandom);
        end
      end
      cr = 1'b0;
      if (m_cnt < CRED && $urandom_range(0, 99) < 45) cr = 1'b1;
      else if ($urandom_range(0, 999) < 2) cr = 1'b1;
      step(cr);
      if (n == 5000) do_reset();
    end
    for (int k = 0; k < WAYS; k++) src_v[k] = 1'b0;
    repeat (3) step(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
